// File: rtl/ov7670_stream_gen_if.sv
// ----------------------------------------------------------------------------
// ov7670_stream_gen_if
// Purpose : Bundles the control inputs and camera-side outputs of the synthetic
//           OV7670 byte-stream source.
// Signals : enable       - level, stream frames while high
//           pattern_sel  - 0 bars, 1 gradient, 2 solid, 3 checker
//           cam_vsync    - frame sync, high during VSYNC lines
//           cam_href     - high while line bytes are valid
//           cam_data     - pixel byte, 8'h00 while cam_href is low
//           frame_done   - one-cycle pulse on the last cycle of each frame
//           frame_cnt    - completed frames, wraps 255->0
//           busy         - high whenever the generator is not idle
// Modports: master - the stream generator
//           slave  - the controller/consumer side
// ----------------------------------------------------------------------------
interface ov7670_stream_gen_if;
    logic       enable;
    logic [1:0] pattern_sel;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic       busy;

    modport master (
        input  enable,
        input  pattern_sel,
        output cam_vsync,
        output cam_href,
        output cam_data,
        output frame_done,
        output frame_cnt,
        output busy
    );

    modport slave (
        output enable,
        output pattern_sel,
        input  cam_vsync,
        input  cam_href,
        input  cam_data,
        input  frame_done,
        input  frame_cnt,
        input  busy
    );
endinterface

// File: rtl/ov7670_stream_gen.sv
// ----------------------------------------------------------------------------
// ov7670_stream_gen
// Purpose : Synthetic OV7670-style camera source. Emits VSYNC/HREF/D[7:0] with
//           camera frame/line framing and RGB565 test patterns, two bytes per
//           pixel (high byte first), one byte per sys_clk.
// Ports   : sys_clk   - byte clock, all logic on rising edge
//           sys_rst_n - asynchronous reset, active low
//           cam_if    - ov7670_stream_gen_if.master (controls + camera outputs)
// Notes   : All outputs are registered. Next-state position (state, h, v) is
//           computed combinationally and the outputs are registered from it, so
//           the outputs always describe the current position of the counters.
// ----------------------------------------------------------------------------
module ov7670_stream_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_BLANK     = 288,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
    input logic                 sys_clk,
    input logic                 sys_rst_n,
    ov7670_stream_gen_if.master cam_if
);

    localparam int unsigned LineLen = 2 * H_ACTIVE + H_BLANK;
    localparam logic [11:0] LineLast = 12'(LineLen - 1);
    localparam logic [11:0] HrefLen  = 12'(2 * H_ACTIVE);
    localparam logic [10:0] BarLast  = 11'(H_ACTIVE / 8 - 1);

    // Counters are 12/10 bits wide; reject parameter sets that do not fit.
    if (LineLen > 4096 || H_ACTIVE < 8 || VSYNC_LINES < 1 || V_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || VSYNC_LINES > 1024 || V_BACK > 1024 ||
        V_ACTIVE > 1024 || V_FRONT > 1024) begin : g_param_check
        $error("ov7670_stream_gen: parameters do not fit counter widths");
    end

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } state_e;

    state_e      r_state;
    logic [11:0] r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [1:0]  r_pat;
    logic [2:0]  r_bar_idx;
    logic [10:0] r_bar_px;
    logic        r_vsync;
    logic        r_href;
    logic [7:0]  r_data;
    logic        r_done;
    logic [7:0]  r_frame_cnt;
    logic        r_busy;

    state_e      w_state_nx;
    logic [11:0] w_h_nx;
    logic [9:0]  w_v_nx;
    logic        w_latch;
    logic [9:0]  w_lines_last;
    logic [2:0]  w_bar_idx_nx;
    logic [10:0] w_bar_px_nx;
    logic [7:0]  w_x;
    logic [15:0] w_bar_color;
    logic [15:0] w_pix;
    logic        w_href_nx;
    logic [7:0]  w_data_nx;
    logic        w_done_nx;

    // Next position in the frame.
    always_comb begin
        w_state_nx   = r_state;
        w_h_nx       = r_h_cnt;
        w_v_nx       = r_v_cnt;
        w_latch      = 1'b0;
        w_lines_last = '0;
        unique case (r_state)
            StVsync:  w_lines_last = 10'(VSYNC_LINES - 1);
            StVback:  w_lines_last = 10'(V_BACK - 1);
            StActive: w_lines_last = 10'(V_ACTIVE - 1);
            StVfront: w_lines_last = 10'(V_FRONT - 1);
            default:  w_lines_last = '0;
        endcase

        if (r_state == StIdle) begin
            if (cam_if.enable) begin
                w_state_nx = StVsync;
                w_h_nx     = '0;
                w_v_nx     = '0;
                w_latch    = 1'b1;
            end
        end else if (r_h_cnt != LineLast) begin
            w_h_nx = r_h_cnt + 12'd1;
        end else begin
            w_h_nx = '0;
            if (r_v_cnt != w_lines_last) begin
                w_v_nx = r_v_cnt + 10'd1;
            end else begin
                w_v_nx = '0;
                unique case (r_state)
                    StVsync:  w_state_nx = StVback;
                    StVback:  w_state_nx = StActive;
                    StActive: w_state_nx = StVfront;
                    StVfront: begin
                        // Frames are never truncated: enable only matters here.
                        if (cam_if.enable) begin
                            w_state_nx = StVsync;
                            w_latch    = 1'b1;
                        end else begin
                            w_state_nx = StIdle;
                        end
                    end
                    default:  w_state_nx = StIdle;
                endcase
            end
        end
    end

    // Bar tracking by counting pixels within the current bar; the last bar
    // absorbs any remainder pixels.
    always_comb begin
        w_bar_idx_nx = r_bar_idx;
        w_bar_px_nx  = r_bar_px;
        if (w_h_nx == '0) begin
            w_bar_idx_nx = '0;
            w_bar_px_nx  = '0;
        end else if (!w_h_nx[0] && r_bar_idx != 3'd7) begin
            if (r_bar_px == BarLast) begin
                w_bar_idx_nx = r_bar_idx + 3'd1;
                w_bar_px_nx  = '0;
            end else begin
                w_bar_px_nx = r_bar_px + 11'd1;
            end
        end
    end

    always_comb begin
        w_bar_color = 16'h0000;
        unique case (w_bar_idx_nx)
            3'd0: w_bar_color = 16'hFFFF;
            3'd1: w_bar_color = 16'hFFE0;
            3'd2: w_bar_color = 16'h07FF;
            3'd3: w_bar_color = 16'h07E0;
            3'd4: w_bar_color = 16'hF81F;
            3'd5: w_bar_color = 16'hF800;
            3'd6: w_bar_color = 16'h001F;
            3'd7: w_bar_color = 16'h0000;
            default: w_bar_color = 16'h0000;
        endcase
    end

    always_comb begin
        w_x   = w_h_nx[8:1];
        w_pix = 16'h0000;
        unique case (r_pat)
            2'd0: w_pix = w_bar_color;
            2'd1: w_pix = {w_x[7:3], w_v_nx[7:2], 5'b00000};
            2'd2: w_pix = SOLID_COLOR;
            2'd3: w_pix = (w_x[5] ^ w_v_nx[5]) ? 16'hFFFF : 16'h0000;
            default: w_pix = 16'h0000;
        endcase
        w_href_nx = (w_state_nx == StActive) && (w_h_nx < HrefLen);
        w_data_nx = 8'h00;
        if (w_href_nx) begin
            w_data_nx = w_h_nx[0] ? w_pix[7:0] : w_pix[15:8];
        end
        w_done_nx = (w_state_nx == StVfront) && (w_v_nx == 10'(V_FRONT - 1)) &&
                    (w_h_nx == LineLast);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= StIdle;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_pat       <= '0;
            r_bar_idx   <= '0;
            r_bar_px    <= '0;
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_data      <= 8'h00;
            r_done      <= 1'b0;
            r_frame_cnt <= 8'h00;
            r_busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_h_cnt   <= w_h_nx;
            r_v_cnt   <= w_v_nx;
            r_bar_idx <= w_bar_idx_nx;
            r_bar_px  <= w_bar_px_nx;
            if (w_latch) begin
                r_pat <= cam_if.pattern_sel;
            end
            r_vsync <= (w_state_nx == StVsync);
            r_href  <= w_href_nx;
            r_data  <= w_data_nx;
            r_done  <= w_done_nx;
            r_busy  <= (w_state_nx != StIdle);
            if (w_done_nx) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign cam_if.cam_vsync  = r_vsync;
    assign cam_if.cam_href   = r_href;
    assign cam_if.cam_data   = r_data;
    assign cam_if.frame_done = r_done;
    assign cam_if.frame_cnt  = r_frame_cnt;
    assign cam_if.busy       = r_busy;

endmodule
